// File: rtl/sync_align_queue_pkg.sv
// Shared widths, tag layout helpers and controller state encoding for the
// sync_align_queue slice.
package sync_pkg;

  localparam int XW_DEF    = 10;
  localparam int YW_DEF    = 10;
  localparam int CIW_DEF   = 8;
  localparam int RW_DEF    = 5;
  localparam int GW_DEF    = 6;
  localparam int BW_DEF    = 5;
  localparam int DEPTH_DEF = 8;
  localparam int ECW_DEF   = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FULL = 2'd2
  } state_t;

  // Tag layout, MSB first: {x, y, r, g, b}
  function automatic int tagWidth(input int xw, input int yw, input int rw,
                                  input int gw, input int bw);
    return xw + yw + rw + gw + bw;
  endfunction

  function automatic int tagBOff();
    return 0;
  endfunction

  function automatic int tagGOff(input int bw);
    return bw;
  endfunction

  function automatic int tagROff(input int gw, input int bw);
    return gw + bw;
  endfunction

  function automatic int tagYOff(input int rw, input int gw, input int bw);
    return rw + gw + bw;
  endfunction

  function automatic int tagXOff(input int yw, input int rw, input int gw,
                                 input int bw);
    return yw + rw + gw + bw;
  endfunction

endpackage

// File: rtl/sync_align_queue_tag_fifo.sv
// Small synchronous FIFO holding pending tags; head is visible combinationally
// and a push and a pop may happen in the same cycle, even when full.
module tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_doPush;
  logic          w_doPop;

  assign empty    = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_doPop  = pop & ~empty;
  assign w_doPush = push & (~w_full | w_doPop);
  assign dout     = r_mem[r_rdPtr];
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sync_align_queue.sv
// Pairs source pixels read from a show-ahead FIFO with in-order homography
// results, flagging coordinate mismatches and orphaned results.
module sync_align_queue
  import sync_pkg::*;
#(
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CIW   = CIW_DEF,
  parameter int RW    = RW_DEF,
  parameter int GW    = GW_DEF,
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ECW   = ECW_DEF
) (
  input  logic                     clk_25,
  input  logic                     rst_n,
  input  logic [XW+YW+3*CIW-1:0]   q,
  input  logic                     rdempty,
  output logic                     rdreq,
  output logic                     rdclk,
  output logic [XW-1:0]            query_x,
  output logic [YW-1:0]            query_y,
  output logic                     start,
  input  logic [XW-1:0]            return_x,
  input  logic [YW-1:0]            return_y,
  input  logic [RW-1:0]            r,
  input  logic [GW-1:0]            g,
  input  logic [BW-1:0]            b,
  input  logic                     ready,
  output logic                     val,
  output logic [XW-1:0]            sync_x,
  output logic [YW-1:0]            sync_y,
  output logic [RW-1:0]            dvi_r,
  output logic [GW-1:0]            dvi_g,
  output logic [BW-1:0]            dvi_b,
  output logic [RW-1:0]            ccd_r,
  output logic [GW-1:0]            ccd_g,
  output logic [BW-1:0]            ccd_b,
  input  logic                     clr,
  output logic                     debug,
  output logic                     underflow,
  output logic [ECW-1:0]           err_cnt,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TW    = tagWidth(XW, YW, RW, GW, BW);
  localparam int X_OFF = tagXOff(YW, RW, GW, BW);
  localparam int Y_OFF = tagYOff(RW, GW, BW);
  localparam int R_OFF = tagROff(GW, BW);
  localparam int G_OFF = tagGOff(BW);
  localparam int B_OFF = tagBOff();

  logic [XW-1:0]  w_qX;
  logic [YW-1:0]  w_qY;
  logic [CIW-1:0] w_qR8;
  logic [CIW-1:0] w_qG8;
  logic [CIW-1:0] w_qB8;
  logic [TW-1:0]  w_pushTag;
  logic [TW-1:0]  w_headTag;
  logic [XW-1:0]  w_headX;
  logic [YW-1:0]  w_headY;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_countNext;
  logic           w_fifoEmpty;
  logic           w_accept;
  logic           w_pop;
  logic           w_mismatch;
  logic           w_orphan;
  logic           w_unusedQ;
  state_t         r_state;
  state_t         w_stateNext;

  logic [XW-1:0]  r_queryX;
  logic [YW-1:0]  r_queryY;
  logic           r_start;
  logic           r_val;
  logic [XW-1:0]  r_syncX;
  logic [YW-1:0]  r_syncY;
  logic [RW-1:0]  r_dviR;
  logic [GW-1:0]  r_dviG;
  logic [BW-1:0]  r_dviB;
  logic [RW-1:0]  r_ccdR;
  logic [GW-1:0]  r_ccdG;
  logic [BW-1:0]  r_ccdB;
  logic           r_debug;
  logic           r_underflow;
  logic [ECW-1:0] r_errCnt;

  assign w_qX  = q[XW+YW+3*CIW-1 -: XW];
  assign w_qY  = q[YW+3*CIW-1 -: YW];
  assign w_qR8 = q[3*CIW-1 -: CIW];
  assign w_qG8 = q[2*CIW-1 -: CIW];
  assign w_qB8 = q[CIW-1:0];

  assign w_pushTag = {w_qX, w_qY, w_qR8[CIW-1 -: RW], w_qG8[CIW-1 -: GW],
                      w_qB8[CIW-1 -: BW]};
  assign w_unusedQ = ^{w_qR8, w_qG8, w_qB8};

  assign w_headX = w_headTag[X_OFF +: XW];
  assign w_headY = w_headTag[Y_OFF +: YW];

  // A result never pops a tag pushed in the same cycle: pop looks at count only
  assign w_pop      = ready & ~w_fifoEmpty;
  assign w_mismatch = w_pop & ((return_x != w_headX) | (return_y != w_headY));
  assign w_orphan   = ready & w_fifoEmpty & ~w_accept;

  tag_fifo #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_tagFifo (
    .clk   (clk_25),
    .rst_n (rst_n),
    .push  (w_accept),
    .pop   (w_pop),
    .din   (w_pushTag),
    .dout  (w_headTag),
    .count (w_count),
    .empty (w_fifoEmpty)
  );

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_countNext = w_count;
    if (w_accept && !w_pop) begin
      w_countNext = w_count + CW'(1);
    end else if (!w_accept && w_pop) begin
      w_countNext = w_count - CW'(1);
    end
    if (w_countNext == '0) begin
      w_stateNext = S_IDLE;
    end else if (w_countNext == CW'(DEPTH)) begin
      w_stateNext = S_FULL;
    end else begin
      w_stateNext = S_BUSY;
    end
  end

  // When full, a word can only be taken if a result frees a slot this cycle
  always_comb begin
    w_accept = 1'b0;
    if (rst_n && !rdempty) begin
      w_accept = (r_state != S_FULL) | w_pop;
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_queryX    <= '0;
      r_queryY    <= '0;
      r_start     <= 1'b0;
      r_val       <= 1'b0;
      r_syncX     <= '0;
      r_syncY     <= '0;
      r_dviR      <= '0;
      r_dviG      <= '0;
      r_dviB      <= '0;
      r_ccdR      <= '0;
      r_ccdG      <= '0;
      r_ccdB      <= '0;
      r_debug     <= 1'b0;
      r_underflow <= 1'b0;
      r_errCnt    <= '0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_queryX <= w_qX;
        r_queryY <= w_qY;
      end
      r_val <= w_pop;
      if (w_pop) begin
        r_syncX <= w_headX;
        r_syncY <= w_headY;
        r_dviR  <= w_headTag[R_OFF +: RW];
        r_dviG  <= w_headTag[G_OFF +: GW];
        r_dviB  <= w_headTag[B_OFF +: BW];
        r_ccdR  <= r;
        r_ccdG  <= g;
        r_ccdB  <= b;
      end
      if (clr) begin
        r_debug     <= 1'b0;
        r_underflow <= 1'b0;
        r_errCnt    <= '0;
      end else begin
        if (w_mismatch) begin
          r_debug <= 1'b1;
          if (r_errCnt != '1) begin
            r_errCnt <= r_errCnt + ECW'(1);
          end
        end
        if (w_orphan) begin
          r_underflow <= 1'b1;
        end
      end
    end
  end

  assign rdreq       = w_accept;
  assign rdclk       = clk_25;
  assign query_x     = r_queryX;
  assign query_y     = r_queryY;
  assign start       = r_start;
  assign val         = r_val;
  assign sync_x      = r_syncX;
  assign sync_y      = r_syncY;
  assign dvi_r       = r_dviR;
  assign dvi_g       = r_dviG;
  assign dvi_b       = r_dviB;
  assign ccd_r       = r_ccdR;
  assign ccd_g       = r_ccdG;
  assign ccd_b       = r_ccdB;
  assign debug       = r_debug;
  assign underflow   = r_underflow;
  assign err_cnt     = r_errCnt;
  assign outstanding = w_count;

endmodule

// File: tb/tb_sync_align_queue.sv
// Scoreboard bench: expected outputs are queued when a result is issued and a
// monitor checks them whenever val rises; flags and counters checked directly.
module tb_sync_align_queue;
  import sync_pkg::*;

  localparam int XW = 10, YW = 10, CIW = 8, RW = 5, GW = 6, BW = 5;
  localparam int DEPTH = 8, ECW = 4;

  typedef struct packed {
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic [RW-1:0] dr;
    logic [GW-1:0] dg;
    logic [BW-1:0] db;
    logic [RW-1:0] cr;
    logic [GW-1:0] cg;
    logic [BW-1:0] cb;
  } exp_t;

  logic clk_25 = 1'b0;
  logic rst_n;
  logic [XW+YW+3*CIW-1:0] q;
  logic rdempty;
  logic rdreq, rdclk, start, val, debug, underflow;
  logic [XW-1:0] query_x, sync_x, return_x;
  logic [YW-1:0] query_y, sync_y, return_y;
  logic [RW-1:0] r, dvi_r, ccd_r;
  logic [GW-1:0] g, dvi_g, ccd_g;
  logic [BW-1:0] b, dvi_b, ccd_b;
  logic ready, clr;
  logic [ECW-1:0] err_cnt;
  logic [$clog2(DEPTH):0] outstanding;

  logic [XW+YW+3*CIW-1:0] srcQ[$];
  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;
  int acceptCnt = 0;

  sync_align_queue #(
    .XW(XW), .YW(YW), .CIW(CIW), .RW(RW), .GW(GW), .BW(BW),
    .DEPTH(DEPTH), .ECW(ECW)
  ) dut (
    .clk_25(clk_25), .rst_n(rst_n), .q(q), .rdempty(rdempty), .rdreq(rdreq),
    .rdclk(rdclk), .query_x(query_x), .query_y(query_y), .start(start),
    .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
    .ready(ready), .val(val), .sync_x(sync_x), .sync_y(sync_y),
    .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b), .ccd_r(ccd_r),
    .ccd_g(ccd_g), .ccd_b(ccd_b), .clr(clr), .debug(debug),
    .underflow(underflow), .err_cnt(err_cnt), .outstanding(outstanding)
  );

  always #20 clk_25 = ~clk_25;

  task automatic refreshSrc();
    rdempty = (srcQ.size() == 0);
    q = (srcQ.size() != 0) ? srcQ[0] : '0;
  endtask

  // Show-ahead source FIFO model driven by the DUT's read acknowledge
  always @(posedge clk_25) begin
    if (rdreq) begin
      acceptCnt++;
      if (srcQ.size() != 0) void'(srcQ.pop_front());
    end
    #1 refreshSrc();
  end

  always @(negedge clk_25) begin
    if (val) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_val: got val=1 sync=%0d,%0d, required no output",
                 sync_x, sync_y);
      end else begin
        exp_t e;
        exp_t a;
        e = expQ.pop_front();
        a = '{sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b};
        if (a !== e) begin
          mismatched++;
          $display("[TB] FAIL output: got sync=%0d,%0d dvi=%0d,%0d,%0d ccd=%0d,%0d,%0d required sync=%0d,%0d dvi=%0d,%0d,%0d ccd=%0d,%0d,%0d",
                   a.sx, a.sy, a.dr, a.dg, a.db, a.cr, a.cg, a.cb,
                   e.sx, e.sy, e.dr, e.dg, e.db, e.cr, e.cg, e.cb);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_25);
  endtask

  task automatic loadWord(input int x, input int y, input logic [7:0] r8,
                          input logic [7:0] g8, input logic [7:0] b8);
    logic [XW-1:0] xv;
    logic [YW-1:0] yv;
    xv = XW'(x);
    yv = YW'(y);
    srcQ.push_back({xv, yv, r8, g8, b8});
    refreshSrc();
  endtask

  task automatic expectOut(input int sx, input int sy, input int dr,
                           input int dg, input int db, input int cr,
                           input int cg, input int cb);
    exp_t e;
    e.sx = XW'(sx); e.sy = YW'(sy);
    e.dr = RW'(dr); e.dg = GW'(dg); e.db = BW'(db);
    e.cr = RW'(cr); e.cg = GW'(cg); e.cb = BW'(cb);
    expQ.push_back(e);
  endtask

  // Drives one cycle of a homography result, starting and ending on a negedge
  task automatic applyStimulus(input int rx, input int ry, input int cr,
                               input int cg, input int cb);
    ready = 1'b1;
    return_x = XW'(rx);
    return_y = YW'(ry);
    r = RW'(cr);
    g = GW'(cg);
    b = BW'(cb);
    @(negedge clk_25);
  endtask

  task automatic waitOutstanding(input int n);
    int budget;
    budget = 0;
    while (outstanding != n && budget < 60) begin
      @(negedge clk_25);
      budget++;
    end
    checkOutput("wait_outstanding", 64'(outstanding), 64'(n));
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b0; clr = 1'b0;
    return_x = '0; return_y = '0; r = '0; g = '0; b = '0;
    refreshSrc();

    // Reset state, with a word already waiting in the source FIFO
    cycles(2);
    loadWord(5, 7, 8'hFF, 8'h80, 8'h01);
    #1;
    checkOutput("rdreq_in_reset", 64'(rdreq), 64'd0);
    checkOutput("reset_outstanding", 64'(outstanding), 64'd0);
    checkOutput("reset_val", 64'(val), 64'd0);
    checkOutput("reset_flags", 64'({debug, underflow, err_cnt}), 64'd0);
    cycles(1);
    rst_n = 1'b1;

    // Basic transaction
    cycles(1);
    checkOutput("start_pulse", 64'(start), 64'd1);
    checkOutput("query_xy", 64'({query_x, query_y}), 64'({10'd5, 10'd7}));
    checkOutput("outstanding_one", 64'(outstanding), 64'd1);
    cycles(1);
    checkOutput("start_low", 64'(start), 64'd0);
    cycles(1);
    expectOut(5, 7, 31, 32, 0, 3, 10, 4);
    applyStimulus(5, 7, 3, 10, 4);
    ready = 1'b0;
    checkOutput("basic_debug", 64'(debug), 64'd0);
    checkOutput("basic_outstanding", 64'(outstanding), 64'd0);
    cycles(1);
    checkOutput("val_one_cycle", 64'(val), 64'd0);

    // Fill to DEPTH with results withheld, then drain in order
    acceptCnt = 0;
    for (int i = 0; i < 10; i++) loadWord(10 + i, 20 + i, 8'hF8, 8'hFC, 8'h08);
    cycles(12);
    checkOutput("full_accepts", 64'(acceptCnt), 64'd8);
    checkOutput("full_outstanding", 64'(outstanding), 64'd8);
    checkOutput("full_state", 64'(dut.r_state), 64'(S_FULL));
    checkOutput("full_rdreq_low", 64'(rdreq), 64'd0);
    ready = 1'b1;
    #1;
    checkOutput("rdreq_resumes", 64'(rdreq), 64'd1);
    for (int i = 0; i < 10; i++) begin
      expectOut(10 + i, 20 + i, 31, 63, 1, i, i, i);
      applyStimulus(10 + i, 20 + i, i, i, i);
    end
    ready = 1'b0;
    checkOutput("drain_accepts", 64'(acceptCnt), 64'd10);
    checkOutput("drain_outstanding", 64'(outstanding), 64'd0);
    checkOutput("drain_debug", 64'(debug), 64'd0);

    // Coordinate mismatch and clear
    loadWord(5, 7, 8'hFF, 8'h80, 8'h01);
    cycles(2);
    expectOut(5, 7, 31, 32, 0, 1, 1, 1);
    applyStimulus(6, 7, 1, 1, 1);
    ready = 1'b0;
    checkOutput("mismatch_debug", 64'(debug), 64'd1);
    checkOutput("mismatch_errcnt", 64'(err_cnt), 64'd1);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    checkOutput("clr_flags", 64'({debug, err_cnt}), 64'd0);

    // Mismatch in the same cycle as clr: clear takes priority
    loadWord(5, 7, 8'hFF, 8'h80, 8'h01);
    cycles(2);
    expectOut(5, 7, 31, 32, 0, 2, 2, 2);
    clr = 1'b1;
    applyStimulus(6, 7, 2, 2, 2);
    clr = 1'b0;
    ready = 1'b0;
    checkOutput("clr_wins", 64'({debug, err_cnt}), 64'd0);

    // 2^ECW+3 mismatches saturate the counter
    for (int i = 0; i < 19; i++) loadWord(i, 0, 8'h00, 8'h00, 8'h00);
    waitOutstanding(8);
    for (int i = 0; i < 19; i++) begin
      expectOut(i, 0, 0, 0, 0, i, 0, 0);
      applyStimulus(1000, 0, i, 0, 0);
    end
    ready = 1'b0;
    checkOutput("errcnt_saturated", 64'(err_cnt), 64'd15);
    checkOutput("sat_debug", 64'(debug), 64'd1);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;

    // Orphan result on an empty queue, then normal operation
    applyStimulus(0, 0, 0, 0, 0);
    ready = 1'b0;
    checkOutput("underflow_set", 64'(underflow), 64'd1);
    checkOutput("underflow_no_val", 64'(val), 64'd0);
    loadWord(3, 4, 8'h10, 8'h20, 8'h30);
    cycles(2);
    expectOut(3, 4, 2, 8, 6, 1, 2, 3);
    applyStimulus(3, 4, 1, 2, 3);
    ready = 1'b0;
    checkOutput("after_underflow_debug", 64'(debug), 64'd0);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;

    // Reset with tags in flight discards them
    for (int i = 0; i < 4; i++) loadWord(i + 1, i + 1, 8'hFF, 8'hFF, 8'hFF);
    waitOutstanding(4);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    checkOutput("midreset_outstanding", 64'(outstanding), 64'd0);
    checkOutput("midreset_outputs",
                64'({val, start, query_x, sync_x, sync_y, dvi_r, ccd_r}), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(i + 1, i + 1, 0, 0, 0);
    ready = 1'b0;
    checkOutput("stale_underflow", 64'(underflow), 64'd1);
    checkOutput("stale_no_val", 64'(val), 64'd0);
    cycles(2);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
